// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter and sequencer for a shared 4-to-1 bus multiplexer.
// Four requesters each present a data word and a request line. One requester
// is granted at a time. The grant drives the mux select S, and the selected
// word is delivered on a registered output Q with a valid flag. A hold-limit
// counter stops one requester from keeping the bus while others wait.
//
// Optional feature (compile-time macro ARB_LOCK_EN):
//   When defined, an extra input `lock` follows `req`. While lock=1 and the
//   owner still requests, the hold-limit timeout is suppressed and the hold
//   counter saturates at MAX_HOLD-1. Dropping lock while others wait then
//   times out on the next edge. When undefined, there is no lock port and
//   the timeout is always active.
//
// Parameters:
//   WIDTH    - width of D0..D3 and Q
//   MAX_HOLD - maximum consecutive granted cycles while another requester
//              waits (1..255)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous reset, active-high
//   req    in   [3:0] request lines, bit i = requester i
//   lock   in   (ARB_LOCK_EN only) suppress the hold-limit timeout
//   D0..D3 in   [WIDTH-1:0] requester data words
//   gnt    out  [3:0] registered one-hot grant, zero when idle
//   S      out  [1:0] registered mux select (index of the granted bit)
//   Q      out  [WIDTH-1:0] registered mux output, one cycle behind gnt/S
//   valid  out  Q carries data from a granted requester
//
// Handshake: a requester raises req[i] and must keep it high until it sees
// gnt[i]. Requests are not latched. The grant lasts while req[i] stays high,
// until a hold-limit timeout. Q/valid for a grant appear one edge after gnt.
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
`ifdef ARB_LOCK_EN
    input  logic             lock,
`endif
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    output logic [3:0]       gnt,
    output logic [1:0]       S,
    output logic [WIDTH-1:0] Q,
    output logic             valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    // Registered arbitration state. `state` is left visible by name so that
    // checkers can bind to it.
    state_t     state;
    state_t     state_n;
    logic [1:0] ptr;
    logic [1:0] ptr_n;
    logic [7:0] cnt;
    logic [7:0] cnt_n;
    logic [3:0] gnt_n;
    logic [1:0] s_n;

    // Combinational helpers.
    logic [1:0]       owner;
    logic [3:0]       owner_mask;
    logic             owner_req;
    logic             others_req;
    logic             at_limit;
    logic             lock_hold;
    logic             timeout;
    logic [1:0]       next_ptr;
    logic [2:0]       win;
    logic [WIDTH-1:0] mux_out;

`ifdef ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Returns {found, index}. Search starts at p and wraps mod 4. The loop
    // runs from the farthest offset to the nearest, so the nearest set bit
    // is the last assignment and wins.
    function automatic logic [2:0] arbitrate(input logic [3:0] r,
                                             input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Owner bookkeeping. S holds the current owner's index in GRANT.
    assign owner      = S;
    assign owner_mask = 4'b0001 << owner;
    assign owner_req  = |(req & owner_mask);
    assign others_req = |(req & ~owner_mask);
    assign at_limit   = (cnt == HOLD_LAST);
    assign timeout    = owner_req && at_limit && others_req && !lock_hold;
    assign next_ptr   = owner + 2'd1;

    // Next-state and next-grant logic.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        gnt_n   = gnt;
        s_n     = S;
        win     = 3'b000;

        case (state)
            IDLE: begin
                if (|req) begin
                    win     = arbitrate(req, ptr);
                    gnt_n   = 4'b0001 << win[1:0];
                    s_n     = win[1:0];
                    cnt_n   = 8'd0;
                    state_n = GRANT;
                end else begin
                    gnt_n = 4'b0000;
                end
            end

            GRANT: begin
                if (!owner_req || timeout) begin
                    // Release or forced handover. Priority moves past the
                    // owner. The owner is masked out, so a timeout never
                    // re-grants it, and a release has no owner bit anyway.
                    // The handover takes effect on this edge, with no idle
                    // cycle in between.
                    ptr_n = next_ptr;
                    win   = arbitrate(req & ~owner_mask, next_ptr);
                    cnt_n = 8'd0;
                    if (win[2]) begin
                        gnt_n = 4'b0001 << win[1:0];
                        s_n   = win[1:0];
                    end else begin
                        gnt_n   = 4'b0000;
                        state_n = IDLE;
                    end
                end else if (lock_hold) begin
                    // Locked owner. The counter stops at the limit so that
                    // dropping lock times out on the very next edge.
                    cnt_n = at_limit ? cnt : cnt + 8'd1;
                end else if (at_limit) begin
                    // At the limit with nobody waiting. The owner keeps
                    // the bus and the counter starts a new window.
                    cnt_n = 8'd0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end

            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            cnt   <= 8'd0;
            gnt   <= 4'b0000;
            S     <= 2'd0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            S     <= s_n;
        end
    end

    // Shared 4-to-1 mux, selected by the registered S.
    always_comb begin
        mux_out = D0;
        case (S)
            2'd0:    mux_out = D0;
            2'd1:    mux_out = D1;
            2'd2:    mux_out = D2;
            2'd3:    mux_out = D3;
            default: mux_out = D0;
        endcase
    end

    // Output register. It samples the word of the owner that is registered
    // now, so Q/valid run one edge behind gnt/S. When idle, Q keeps its
    // last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q     <= '0;
            valid <= 1'b0;
        end else if (state == GRANT) begin
            Q     <= mux_out;
            valid <= 1'b1;
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 8;

    logic             clk;
    logic             rst;
    logic [3:0]       req;
`ifdef ARB_LOCK_EN
    logic             lock;
`endif
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [3:0]       gnt;
    logic [1:0]       s;
    logic [WIDTH-1:0] q;
    logic             valid;

    int total;
    int bad;

    mux4_rr_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
`ifdef ARB_LOCK_EN
        .lock  (lock),
`endif
        .D0    (d0),
        .D1    (d1),
        .D2    (d2),
        .D3    (d3),
        .gnt   (gnt),
        .S     (s),
        .Q     (q),
        .valid (valid)
    );

    // Clock and a global time bound.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time bound reached");
    end

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_g;
        int         o;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 4'b0000;
`ifdef ARB_LOCK_EN
        lock  = 1'b0;
`endif
        d0 = 4'd1;
        d1 = 4'd2;
        d2 = 4'd0;
        d3 = 4'd0;

        // Reset values.
        step();
        check("rst_gnt", 16'(gnt), 16'h0);
        check("rst_s", 16'(s), 16'h0);
        check("rst_q", 16'(q), 16'h0);
        check("rst_valid", 16'(valid), 16'h0);
        rst = 1'b0;
        step();
        check("idle_gnt", 16'(gnt), 16'h0);

        // Single requester 2. Q lags the grant by one edge.
        req = 4'b0100;
        d2  = 4'd5;
        step();
        check("single_gnt", 16'(gnt), 16'h4);
        check("single_s", 16'(s), 16'h2);
        check("single_valid0", 16'(valid), 16'h0);
        step();
        check("single_q5", 16'(q), 16'h5);
        check("single_valid1", 16'(valid), 16'h1);
        check("single_gnt_hold", 16'(gnt), 16'h4);
        d2 = 4'd3;
        step();
        check("single_q3", 16'(q), 16'h3);
        req = 4'b0000;
        step();
        check("rel2_gnt", 16'(gnt), 16'h0);
        check("rel2_valid_lag", 16'(valid), 16'h1);
        step();
        check("rel2_valid", 16'(valid), 16'h0);
        check("rel2_q_hold", 16'(q), 16'h3);

        // ptr is 3 now. Requester 3 releases to idle, then ptr wraps to 0.
        req = 4'b1000;
        d3  = 4'd9;
        step();
        check("wrap_gnt3", 16'(gnt), 16'h8);
        check("wrap_s3", 16'(s), 16'h3);
        step();
        check("wrap_q9", 16'(q), 16'h9);
        req = 4'b0000;
        step();
        check("wrap_idle_gnt", 16'(gnt), 16'h0);
        step();
        check("wrap_idle_valid", 16'(valid), 16'h0);
        check("wrap_q_hold", 16'(q), 16'h9);
        req = 4'b1001;
        step();
        check("wrap_gnt0", 16'(gnt), 16'h1);
        check("wrap_s0", 16'(s), 16'h0);
        req = 4'b0000;
        step();
        step();

        // Asynchronous reset mid-grant (gnt=0100, req=1111).
        req = 4'b0100;
        d2  = 4'd7;
        step();
        check("pre_rst_gnt", 16'(gnt), 16'h4);
        req = 4'b1111;
        step();
        check("pre_rst_gnt_hold", 16'(gnt), 16'h4);
        check("pre_rst_q", 16'(q), 16'h7);
        #2;
        rst = 1'b1;
        #1;
        check("async_gnt", 16'(gnt), 16'h0);
        check("async_s", 16'(s), 16'h0);
        check("async_q", 16'(q), 16'h0);
        check("async_valid", 16'(valid), 16'h0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_gnt", 16'(gnt), 16'h1);
        check("post_rst_s", 16'(s), 16'h0);

        // Rotation. Each owner drops req after two cycles: 0,1,2,3,0,1.
        for (int k = 0; k < 5; k++) begin
            o     = k % 4;
            exp_g = 4'b0001 << o;
            check("rr_first", 16'(gnt), 16'(exp_g));
            step();
            check("rr_second", 16'(gnt), 16'(exp_g));
            check("rr_valid", 16'(valid), 16'h1);
            req[o] = 1'b0;
            step();
            req[o] = 1'b1;
        end
        check("rr_final", 16'(gnt), 16'h2);

        // Hold-limit timeout with req=0011 held: 8 cycles to 0, 8 to 1, then 0.
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 17; i++) begin
            step();
            exp_g = (i < 8) ? 4'b0001 : ((i < 16) ? 4'b0010 : 4'b0001);
            check("timeout_gnt", 16'(gnt), 16'(exp_g));
        end
        // A lone requester keeps the grant indefinitely.
        req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            step();
            check("lone_gnt", 16'(gnt), 16'h1);
        end

`ifdef ARB_LOCK_EN
        // Lock holds requester 0 past the limit. Dropping lock hands over.
        do_reset();
        lock = 1'b1;
        req  = 4'b0011;
        for (int i = 1; i < 20; i++) begin
            step();
            check("lock_gnt", 16'(gnt), 16'h1);
        end
        lock = 1'b0;
        step();
        check("unlock_gnt", 16'(gnt), 16'h2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
